// File: rtl/fast2slow_counter_pkg.sv
// Shared constants and Gray-code helpers for the fast-to-slow counter transfer.
// The helpers work on a fixed wide vector; callers zero-extend and truncate.
`timescale 1ns/1ps
package fast2slow_counter_pkg;

  localparam int DEFAULT_WIDTH       = 4;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int MAX_W               = 32;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  // Zero-extended Gray input decodes to the same binary value in the low bits.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b = g;
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Brings the slow reference into the clk1 domain and emits a one-cycle strobe
// on each rising edge seen at the synchronizer output.
`timescale 1ns/1ps
module sync_edge_detect
  import fast2slow_counter_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk1,
  input  logic reset,
  input  logic clk2,
  output logic slow_tick
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  logic hist_q;

  always_ff @(posedge clk1) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk2};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Strobe only after the edge has passed every synchronizer stage.
  assign slow_tick = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/fast2slow_counter.sv
// Free-running clk1 counter whose value is copied, via a Gray register, into a
// second register once per rising edge of the slow reference clk2.
`timescale 1ns/1ps
module fast2slow_counter
  import fast2slow_counter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             clk2,
  output logic [WIDTH-1:0] count_1,
  output logic [WIDTH-1:0] count_2
);

  logic [WIDTH-1:0] gray_q;
  logic             slow_tick;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk1      (clk1),
    .reset     (reset),
    .clk2      (clk2),
    .slow_tick (slow_tick)
  );

  // gray_q lags count_1 by one edge, so count_2 lands two counts behind.
  always_ff @(posedge clk1) begin
    if (reset) begin
      count_1 <= '0;
      gray_q  <= '0;
      count_2 <= '0;
    end else begin
      count_1 <= count_1 + 1'b1;
      gray_q  <= WIDTH'(bin2gray(MAX_W'(count_1)));
      if (slow_tick) begin
        count_2 <= WIDTH'(gray2bin(MAX_W'(gray_q)));
      end
    end
  end

endmodule

// File: tb/tb_fast2slow_counter.sv
// Directed bench for fast2slow_counter: sequence, wrap, hold, reset, glitch and
// asynchronous slow-clock scenarios, checked with immediate assertions.
`timescale 1ns/1ps
module tb_fast2slow_counter;

  localparam int W  = 4;
  localparam int SS = 2;

  logic         clk1 = 1'b0;
  logic         reset = 1'b1;
  logic         clk2 = 1'b0;
  logic [W-1:0] count_1;
  logic [W-1:0] count_2;

  int tests = 0;
  int fails = 0;

  // Reference timing: clk2 samples taken on each clk1 edge.
  logic [W-1:0] exp_c1;
  logic [W-1:0] exp_c2;
  logic [SS:0]  h;
  logic         exp_tick;
  logic         prev_tick;
  logic [W-1:0] prev_c2;

  fast2slow_counter #(
    .WIDTH       (W),
    .SYNC_STAGES (SS)
  ) u_dut (
    .clk1    (clk1),
    .reset   (reset),
    .clk2    (clk2),
    .count_1 (count_1),
    .count_2 (count_2)
  );

  always #5 clk1 = ~clk1;

  always @(posedge clk1) begin
    if (reset) begin
      exp_c1 <= '0;
      exp_c2 <= '0;
      h      <= '0;
    end else begin
      exp_c1 <= exp_c1 + 1'b1;
      if (exp_tick) exp_c2 <= exp_c1 - 1'b1;
      h <= {h[SS-1:0], clk2};
    end
  end

  assign exp_tick = h[SS-1] & ~h[SS];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic r);
    @(negedge clk1);
    clk2  = v;
    reset = r;
    @(posedge clk1);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(posedge clk1);
    #1;
    chk("reset_c1", count_1, 4'd0);
    chk("reset_c2", count_2, 4'd0);

    // clk2 at half the clk1 rate: updates on every second edge
    for (int i = 1; i <= 17; i++) begin
      step(1'(i % 2), 1'b0);
      chk("seq_c1", count_1, 4'(i));
      chk("seq_c2", count_2, 4'((i < 3) ? 0 : ((i % 2 == 1) ? i - 2 : i - 3)));
      if (i >= 3 && (i % 2 == 1)) chk("upd_rel", count_2, 4'(count_1 - 4'd2));
    end

    // Let the last pending edge drain, then hold clk2 low
    for (int i = 18; i <= 20; i++) step(1'b0, 1'b0);
    chk("settle_c2", count_2, 4'd1);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0);
      chk("hold_c2", count_2, 4'd1);
    end
    chk("hold_c1", count_1, 4'd8);
    chk("hold_c1_model", count_1, exp_c1);

    // Glitch narrower than a clk1 period, between two edges
    #1 clk2 = 1'b1;
    #2 clk2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      chk("glitch_c2", count_2, 4'd1);
      chk("glitch_c1", count_1, 4'(9 + i));
    end

    // Run up to count_1 = 9 and reset mid-run
    for (int k = 0; k < 32 && exp_c1 != 4'd9; k++) step(1'b0, 1'b0);
    chk("pre_reset_c1", count_1, 4'd9);
    step(1'b0, 1'b1);
    chk("midreset_c1", count_1, 4'd0);
    chk("midreset_c2", count_2, 4'd0);
    step(1'b0, 1'b0);
    chk("release_c1", count_1, 4'd1);
    chk("release_c2", count_2, 4'd0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
    chk("pre_rise_c1", count_1, 4'd13);

    // Detection latency after a clk2 rise, landing on the count_1 = 0 wrap
    step(1'b1, 1'b0);
    chk("lat0_c2", count_2, 4'd0);
    step(1'b1, 1'b0);
    chk("lat1_c2", count_2, 4'd0);
    step(1'b1, 1'b0);
    chk("wrap0_c1", count_1, 4'd0);
    chk("wrap0_c2", count_2, 4'd14);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Asynchronous clk2 with a 37 ns period
    prev_tick = 1'b0;
    prev_c2   = count_2;
    fork
      begin
        #0.25;
        repeat (40) #18.5 clk2 = ~clk2;
      end
      begin
        for (int k = 0; k < 80; k++) begin
          @(posedge clk1);
          #1;
          chk("async_c1", count_1, exp_c1);
          chk("async_c2", count_2, exp_c2);
          chk("async_tick", W'(u_dut.slow_tick), W'(exp_tick));
          chk("async_tick_pair", W'(prev_tick & u_dut.slow_tick), '0);
          if (count_2 !== prev_c2) chk("async_rel", count_2, 4'(count_1 - 4'd2));
          prev_tick = u_dut.slow_tick;
          prev_c2   = count_2;
        end
      end
    join

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
